blit_scheduler: RTL and testbench
=================================

BLIT_SCHEDULER -- requirements
Module: blit_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_SPRITES, default 46, giving the number of object-table entries scanned per frame (entry 0 = ship/background control, entries 1-15 = enemies, entries 16-45 = bullets).
REQ-002 The module SHALL have parameter BKG_ROWS, default 480, giving the background rows drawn per frame.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port vblank, input, 1 bit: the level vertical-blank flag from the video timing block.
REQ-006 The module SHALL have port reg_addr, output, 6 bits: the object-table read address.
REQ-007 The module SHALL have port reg_data, input, 32 bits: the object-table read data, valid exactly 1 clk after reg_addr.
REQ-008 The module SHALL have port loco_data, output, 32 bits: the registered entry presented to the blitter.
REQ-009 The module SHALL have ports fb_bkg (output, 1 bit), DrawY (output, 10 bits) and BKG_X (output, 9 bits): the background pass controls.
REQ-010 The module SHALL have ports fb_en (output, 1 bit), spriteX (output, 5 bits) and spriteY (output, 5 bits): the sprite pass controls.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a frame is being drawn.
REQ-012 The module SHALL have ports frame_done (output, 1 bit) and overrun (output, 1 bit): single-cycle status pulses.

Function
REQ-013 vblank SHALL be registered once; start is asserted when the registered value is 0 and the current vblank is 1 (rising edge).
REQ-014 The FSM SHALL use these states: IDLE, LOAD0, WAIT0, BKG, FETCH, WAIT, SPRITE, DONE.
REQ-015 On start in IDLE, the FSM SHALL go to LOAD0 (reg_addr=0) and then WAIT0; in WAIT0 it SHALL capture reg_data into loco_data, clear DrawY and BKG_X, and go to BKG.
REQ-016 In BKG, fb_bkg SHALL be 1 and BKG_X SHALL increment 0..319 each clk; at 319 it SHALL wrap to 0 and DrawY SHALL increment; after DrawY=BKG_ROWS-1 and BKG_X=319 the FSM SHALL go to FETCH with idx=0. One pass is exactly BKG_ROWS*320 cycles.
REQ-017 In FETCH, reg_addr SHALL equal idx; the FSM SHALL then go to WAIT, where loco_data is loaded from reg_data and spriteX and spriteY are cleared.
REQ-018 In SPRITE, fb_en SHALL be 1; spriteX SHALL increment each clk, and spriteY SHALL increment when spriteX wraps from 31 to 0. After (31,31) the FSM SHALL increment idx and go to FETCH, or go to DONE if idx=NUM_SPRITES-1. One pass is exactly 1024 cycles.
REQ-019 fb_en and fb_bkg SHALL never be 1 in the same cycle, and both SHALL be 0 outside BKG and SPRITE.
REQ-020 DONE SHALL last 1 clk, pulse frame_done, and return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A start while busy=1 SHALL be ignored, SHALL pulse overrun for 1 clk, and SHALL NOT disturb counters or state.
REQ-023 Counters SHALL be exact width, with no arithmetic overflow: idx is 6 bits, DrawY 10 bits, BKG_X 9 bits.
REQ-024 reg_addr SHALL hold its last value outside LOAD0 and FETCH.

Reset
REQ-025 When rst=1 at a clk edge, the module SHALL set state=IDLE, all counters=0, loco_data=0, reg_addr=0, all strobes and pulses=0, and the vblank history=1 so that a vblank already high does not start a frame.
REQ-026 A reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done pulse.

Configuration
REQ-027 With BLIT_SKIP_DEAD_EN defined, WAIT SHALL go to SPRITE only if reg_data[23]=1; otherwise it SHALL advance idx (or go to DONE) directly, so a dead entry costs 2 cycles.
REQ-028 Without BLIT_SKIP_DEAD_EN, every entry SHALL be swept for 1024 cycles regardless of bit 23, and the blitter gates the writes.

Structure
REQ-029 A shared package blit_pkg SHALL hold: the state enum, FB_WIDTH=320, SPRITE_DIM=32, LIVE_BIT=23, and the field positions of loco_data (y [8:0], x [17:9], sprite [22:18]).
REQ-030 The block SHALL contain exactly one sub-module, xy_counter: a parameterised wrap counter pair (X max, Y max, increment enable, last flag), used for both the BKG and SPRITE sweeps.

Verification
REQ-031 Scenario 1: rst, then a vblank rise -> busy=1 on the 2nd clk; fb_bkg is high for exactly 153600 cycles with final DrawY=479 and BKG_X=319.
REQ-032 Scenario 2: a table with entries 1 and 5 live and the rest dead, with BLIT_SKIP_DEAD_EN defined -> fb_en is high for exactly 2048 cycles, loco_data equals entries 1 and 5 during those cycles, and frame_done pulses once.
REQ-033 Scenario 3: the same table without the macro -> fb_en is high for 46*1024=47104 cycles.
REQ-034 Scenario 4: a second vblank rise during BKG -> overrun pulses for 1 clk and the frame completes unchanged.
REQ-035 Scenario 5: rst asserted during SPRITE with idx=3 -> the next clk shows IDLE, fb_en=0, busy=0, no frame_done, and loco_data=0.
REQ-036 Scenario 6: vblank held high across the release of rst -> no start until vblank falls and rises again.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and constants for the blit scheduler: FSM states, sweep
// dimensions and the field layout of an object-table entry.
package blit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        WAIT0,
        BKG,
        FETCH,
        WAIT,
        SPRITE,
        DONE
    } state_t;

    localparam int FB_WIDTH   = 320;
    localparam int SPRITE_DIM = 32;
    localparam int LIVE_BIT   = 23;

    // Object-table entry layout as seen by the blitter
    localparam int LOCO_Y_LSB   = 0;
    localparam int LOCO_Y_MSB   = 8;
    localparam int LOCO_X_LSB   = 9;
    localparam int LOCO_X_MSB   = 17;
    localparam int LOCO_SPR_LSB = 18;
    localparam int LOCO_SPR_MSB = 22;

    function automatic logic entry_live(input logic [31:0] entry);
        return entry[LIVE_BIT];
    endfunction

endpackage

// File: rtl/blit_scheduler_xy_counter.sv
// Wrap counter pair: x counts 0..X_MAX, y advances when x wraps.
// last flags the final (X_MAX, Y_MAX) position of the sweep.
module xy_counter #(
    parameter int XW    = 9,
    parameter int YW    = 10,
    parameter int X_MAX = 319,
    parameter int Y_MAX = 479
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blit_scheduler.sv
// Per-frame blit scheduler: on a vblank rise, sweeps the background, then
// sweeps a 32x32 window for every object-table entry. Build option
// BLIT_SKIP_DEAD_EN skips the sweep for entries whose live bit is clear.
module blit_scheduler
    import blit_pkg::*;
#(
    parameter int NUM_SPRITES = 46,
    parameter int BKG_ROWS    = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    output logic [5:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] loco_data,
    output logic        fb_bkg,
    output logic [9:0]  DrawY,
    output logic [8:0]  BKG_X,
    output logic        fb_en,
    output logic [4:0]  spriteX,
    output logic [4:0]  spriteY,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_SPRITES - 1);

    state_t     state_reg;
    logic [5:0] idx_reg;
    logic       vblank_reg;
    logic       start;
    logic       idx_last;
    logic [5:0] idx_next;
    logic       bkg_last;
    logic       spr_last;
    logic       bkg_inc;
    logic       bkg_clr;
    logic       spr_inc;
    logic       spr_clr;

    assign start    = vblank && !vblank_reg;
    assign idx_last = (idx_reg == LAST_IDX);
    assign idx_next = idx_reg + 6'd1;

    // Background counter holds at its final position so DrawY/BKG_X stay readable
    assign bkg_inc = (state_reg == BKG) && !bkg_last;
    assign bkg_clr = (state_reg == WAIT0);
    assign spr_inc = (state_reg == SPRITE);
    assign spr_clr = (state_reg == WAIT);

    xy_counter #(
        .XW    (9),
        .YW    (10),
        .X_MAX (FB_WIDTH - 1),
        .Y_MAX (BKG_ROWS - 1)
    ) u_bkg_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bkg_clr),
        .en   (bkg_inc),
        .x    (BKG_X),
        .y    (DrawY),
        .last (bkg_last)
    );

    xy_counter #(
        .XW    (5),
        .YW    (5),
        .X_MAX (SPRITE_DIM - 1),
        .Y_MAX (SPRITE_DIM - 1)
    ) u_spr_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (spr_clr),
        .en   (spr_inc),
        .x    (spriteX),
        .y    (spriteY),
        .last (spr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            vblank_reg <= 1'b1;
            reg_addr   <= '0;
            loco_data  <= '0;
            fb_bkg     <= 1'b0;
            fb_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vblank_reg <= vblank;
            overrun    <= start && (state_reg != IDLE);
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        reg_addr  <= '0;
                        busy      <= 1'b1;
                        state_reg <= LOAD0;
                    end
                end
                LOAD0: state_reg <= WAIT0;
                WAIT0: begin
                    loco_data <= reg_data;
                    fb_bkg    <= 1'b1;
                    state_reg <= BKG;
                end
                BKG: begin
                    if (bkg_last) begin
                        fb_bkg    <= 1'b0;
                        idx_reg   <= '0;
                        reg_addr  <= '0;
                        state_reg <= FETCH;
                    end
                end
                FETCH: state_reg <= WAIT;
                WAIT: begin
                    loco_data <= reg_data;
`ifdef BLIT_SKIP_DEAD_EN
                    if (!entry_live(reg_data)) begin
                        if (idx_last) begin
                            frame_done <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            reg_addr  <= idx_next;
                            state_reg <= FETCH;
                        end
                    end else begin
                        fb_en     <= 1'b1;
                        state_reg <= SPRITE;
                    end
`else
                    fb_en     <= 1'b1;
                    state_reg <= SPRITE;
`endif
                end
                SPRITE: begin
                    if (spr_last) begin
                        fb_en <= 1'b0;
                        if (idx_last) begin
                            frame_done <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            reg_addr  <= idx_next;
                            state_reg <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blit_scheduler.sv
// Randomized self-checking bench for blit_scheduler with a reduced frame size.
module tb_blit_scheduler;

    localparam int NS  = 6;
    localparam int BR  = 3;
    localparam int FBW = 320;
`ifdef BLIT_SKIP_DEAD_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank = 1'b0;
    logic [5:0]  reg_addr;
    logic [31:0] reg_data = '0;
    logic [31:0] loco_data;
    logic        fb_bkg;
    logic [9:0]  DrawY;
    logic [8:0]  BKG_X;
    logic        fb_en;
    logic [4:0]  spriteX;
    logic [4:0]  spriteY;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    blit_scheduler #(.NUM_SPRITES(NS), .BKG_ROWS(BR)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .loco_data  (loco_data),
        .fb_bkg     (fb_bkg),
        .DrawY      (DrawY),
        .BKG_X      (BKG_X),
        .fb_en      (fb_en),
        .spriteX    (spriteX),
        .spriteY    (spriteY),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Object table with one-cycle registered read
    logic [31:0] tbl [0:63];
    always @(posedge clk) reg_data <= tbl[reg_addr];

    int checks = 0;
    int errors = 0;

    // Expected sweep order for the current frame
    int exp_list [0:63];
    int exp_n = 0;
    int exp_busy = 0;

    // Running totals kept by the monitor
    int tot_bkg = 0, tot_en = 0, tot_busy = 0, tot_done = 0, tot_ovr = 0;
    int tot_ovl = 0, tot_idle = 0, err_pos = 0, err_loco = 0;
    int bkg_run = 0, en_run = 0;

    always @(negedge clk) begin
        int k;
        int p;
        if (!busy) begin
            bkg_run = 0;
            en_run  = 0;
        end
        if (fb_bkg && fb_en) tot_ovl++;
        if (!busy && (fb_bkg || fb_en)) tot_idle++;
        if (fb_bkg) begin
            tot_bkg++;
            if (BKG_X != 9'(bkg_run % FBW) || DrawY != 10'(bkg_run / FBW)) err_pos++;
            if (loco_data !== tbl[0]) err_loco++;
            bkg_run++;
        end
        if (fb_en) begin
            tot_en++;
            k = en_run / 1024;
            p = en_run % 1024;
            if (spriteX != 5'(p % 32) || spriteY != 5'(p / 32)) err_pos++;
            if (k >= exp_n) err_loco++;
            else if (loco_data !== tbl[exp_list[k]]) err_loco++;
            en_run++;
        end
        if (busy) tot_busy++;
        if (frame_done) tot_done++;
        if (overrun) tot_ovr++;
    end

    bit busy_after_start, timed_out;
    int d_bkg, d_en, d_busy, d_done, d_ovr, d_ovl, d_idle, d_pos, d_loco;
    int s_bkg, s_en, s_busy, s_done, s_ovr, s_ovl, s_idle, s_pos, s_loco;

    task automatic build_model();
        bit swept;
        exp_n    = 0;
        exp_busy = 3 + BR * FBW;
        for (int e = 0; e < NS; e++) begin
            swept = !SKIP || tbl[e][23];
            if (swept) begin
                exp_list[exp_n] = e;
                exp_n++;
            end
            exp_busy += 2 + (swept ? 1024 : 0);
        end
    endtask

    task automatic snapshot();
        s_bkg = tot_bkg; s_en = tot_en; s_busy = tot_busy; s_done = tot_done;
        s_ovr = tot_ovr; s_ovl = tot_ovl; s_idle = tot_idle; s_pos = err_pos;
        s_loco = err_loco;
    endtask

    // Drives one frame (optionally with a second vblank rise mid-background) and measures deltas
    task automatic do_frame(input bit inject);
        build_model();
        snapshot();
        @(negedge clk) vblank = 1'b1;
        @(posedge clk);
        #1 busy_after_start = busy;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        if (inject) begin
            for (int i = 0; i < 20 && !fb_bkg; i++) @(negedge clk);
            repeat (100 + $urandom_range(0, 300)) @(negedge clk);
            vblank = 1'b1;
            repeat (3) @(negedge clk);
            vblank = 1'b0;
        end
        timed_out = 1'b1;
        for (int i = 0; i < exp_busy + 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        d_bkg = tot_bkg - s_bkg; d_en = tot_en - s_en; d_busy = tot_busy - s_busy;
        d_done = tot_done - s_done; d_ovr = tot_ovr - s_ovr; d_ovl = tot_ovl - s_ovl;
        d_idle = tot_idle - s_idle; d_pos = err_pos - s_pos; d_loco = err_loco - s_loco;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, fb_en, fb_bkg, frame_done, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", {busy, fb_en, fb_bkg, frame_done, overrun});
        end
        checks++;
        if (loco_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_loco got %h want 0", loco_data);
        end
        checks++;
        if (reg_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", reg_addr);
        end
        checks++;
        if ({DrawY, BKG_X, spriteX, spriteY} !== 29'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", DrawY, BKG_X, spriteX, spriteY);
        end
        rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_vblank_held();
        int busy_cnt;
        @(negedge clk) rst = 1'b1;
        vblank = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL vblank_held_start got %0d busy cycles want 0", busy_cnt);
        end
        vblank = 1'b0;
        repeat (2) @(negedge clk);
        for (int e = 0; e < 64; e++) tbl[e] = $urandom;
        do_frame(1'b0);
        checks++;
        if (!busy_after_start || timed_out || d_done != 1) begin
            errors++;
            $display("FAIL vblank_rerise got busy=%0d timeout=%0d done=%0d want 1 0 1",
                     busy_after_start, timed_out, d_done);
        end
        $display("vblank_held: busy_cnt=%0d done=%0d", busy_cnt, d_done);
    endtask

    task automatic test_frames();
        for (int it = 0; it < 4; it++) begin
            for (int e = 0; e < 64; e++) begin
                tbl[e] = $urandom;
                if (it == 0) tbl[e][23] = (e == 1 || e == 5);
            end
            do_frame(1'b0);
            checks++;
            if (busy_after_start !== 1'b1 || timed_out) begin
                errors++;
                $display("FAIL frame%0d_start busy=%0d timeout=%0d want 1 0", it, busy_after_start, timed_out);
            end
            checks++;
            if (d_bkg != BR * FBW) begin
                errors++;
                $display("FAIL frame%0d_bkg_cycles got %0d want %0d", it, d_bkg, BR * FBW);
            end
            checks++;
            if (d_en != exp_n * 1024) begin
                errors++;
                $display("FAIL frame%0d_en_cycles got %0d want %0d", it, d_en, exp_n * 1024);
            end
            checks++;
            if (d_busy != exp_busy) begin
                errors++;
                $display("FAIL frame%0d_busy_cycles got %0d want %0d", it, d_busy, exp_busy);
            end
            checks++;
            if (d_done != 1 || d_ovr != 0) begin
                errors++;
                $display("FAIL frame%0d_pulses got done=%0d ovr=%0d want 1 0", it, d_done, d_ovr);
            end
            checks++;
            if (d_pos != 0 || d_loco != 0) begin
                errors++;
                $display("FAIL frame%0d_sweep got pos_err=%0d loco_err=%0d want 0 0", it, d_pos, d_loco);
            end
            checks++;
            if (d_ovl != 0 || d_idle != 0) begin
                errors++;
                $display("FAIL frame%0d_strobe_excl got overlap=%0d idle=%0d want 0 0", it, d_ovl, d_idle);
            end
            checks++;
            if (DrawY != 10'(BR - 1) || BKG_X != 9'd319) begin
                errors++;
                $display("FAIL frame%0d_bkg_final got %0d/%0d want %0d/319", it, DrawY, BKG_X, BR - 1);
            end
            $display("frame%0d: swept=%0d bkg=%0d en=%0d busy=%0d done=%0d", it, exp_n, d_bkg, d_en, d_busy, d_done);
        end
    endtask

    task automatic test_overrun();
        for (int e = 0; e < 64; e++) tbl[e] = $urandom;
        do_frame(1'b1);
        checks++;
        if (d_ovr != 1) begin
            errors++;
            $display("FAIL overrun_pulse got %0d want 1", d_ovr);
        end
        checks++;
        if (timed_out || d_busy != exp_busy || d_done != 1) begin
            errors++;
            $display("FAIL overrun_frame got busy=%0d done=%0d timeout=%0d want %0d 1 0",
                     d_busy, d_done, timed_out, exp_busy);
        end
        checks++;
        if (d_en != exp_n * 1024 || d_bkg != BR * FBW || d_loco != 0 || d_pos != 0) begin
            errors++;
            $display("FAIL overrun_sweep got en=%0d bkg=%0d loco_err=%0d pos_err=%0d want %0d %0d 0 0",
                     d_en, d_bkg, d_loco, d_pos, exp_n * 1024, BR * FBW);
        end
        $display("overrun: ovr=%0d busy=%0d done=%0d", d_ovr, d_busy, d_done);
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        for (int e = 0; e < 64; e++) begin
            tbl[e] = $urandom;
            tbl[e][23] = 1'b1;
        end
        build_model();
        snapshot();
        @(negedge clk) vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        found = 1'b0;
        for (int i = 0; i < exp_busy + 200; i++) begin
            @(negedge clk);
            if (fb_en && reg_addr == 6'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach got no sprite pass at idx 3 want found");
        end
        repeat ($urandom_range(0, 500)) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, fb_en, fb_bkg, frame_done} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_strobes got %b want 0000", {busy, fb_en, fb_bkg, frame_done});
        end
        checks++;
        if (loco_data !== 32'h0 || reg_addr !== 6'd0) begin
            errors++;
            $display("FAIL midreset_regs got loco=%h addr=%0d want 0 0", loco_data, reg_addr);
        end
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (tot_done != s_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone got done=%0d busy=%0d want 0 0", tot_done - s_done, busy);
        end
        $display("midreset: found=%0d done=%0d", found, tot_done - s_done);
    endtask

    initial begin
        for (int e = 0; e < 64; e++) tbl[e] = '0;
        test_reset();
        test_vblank_held();
        test_frames();
        test_overrun();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
